// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the button/switch conditioning stage.
// Optional auto-repeat is enabled with the BTN_REPEAT_EN macro.
package btn_cond_pkg;

   localparam int SYNC_DEPTH = 2;

   localparam int BTN_CONFIRM = 0;
   localparam int BTN_BACK    = 1;
   localparam int BTN_UP      = 2;
   localparam int BTN_DOWN    = 3;
   localparam int BTN_RST     = 4;

   typedef enum logic {
      DB_IDLE,
      DB_PENDING
   } db_state_e;

   // A zero-length window would never accept a level, so floor at one cycle.
   function automatic int ms_to_cycles(input int freq, input int ms);
      int c;
      c = freq / 1000 * ms;
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/btn_conditioner_debounce_cell.sv
// One-bit synchroniser + debouncer with registered press/release pulses.
// Auto-repeat of the press pulse is built only when BTN_REPEAT_EN is defined.
module debounce_cell
   import btn_cond_pkg::*;
#(
   parameter int DB_CYCLES     = 4
`ifdef BTN_REPEAT_EN
  ,parameter int HOLD_CYCLES   = 10
  ,parameter int REPEAT_CYCLES = 5
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  s2;
   db_state_e             state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  stable, stable_n;
   logic                  press_n, rel_n;
   logic                  accept;
   logic                  rpt;
   logic                  press_q, rel_q;

   assign s2 = sync_q[SYNC_DEPTH-1];

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      stable_n = stable;
      press_n  = 1'b0;
      rel_n    = 1'b0;
      accept   = 1'b0;
      unique case (state)
         DB_IDLE: begin
            cnt_n = '0;
            if (s2 != stable) begin
               if (cnt == CW'(DB_CYCLES - 1)) begin
                  accept = 1'b1;
               end else begin
                  state_n = DB_PENDING;
                  cnt_n   = cnt + CW'(1);
               end
            end
         end
         DB_PENDING: begin
            if (s2 == stable) begin
               state_n = DB_IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
               accept  = 1'b1;
               state_n = DB_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = DB_IDLE;
            cnt_n   = '0;
         end
      endcase
      if (accept) begin
         stable_n = s2;
         press_n  = s2;
         rel_n    = ~s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state   <= DB_IDLE;
         cnt     <= '0;
         stable  <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_DEPTH-2:0], raw};
         state   <= state_n;
         cnt     <= cnt_n;
         stable  <= stable_n;
         press_q <= press_n | rpt;
         rel_q   <= rel_n;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                       : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] tgt;
   logic          first_q;

   // First repeat waits the long hold, later ones the short interval.
   assign tgt = first_q ? HW'(HOLD_CYCLES - 1) : HW'(REPEAT_CYCLES - 1);
   assign rpt = stable & ~accept & (hold_cnt == tgt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         first_q  <= 1'b1;
      end else if (!stable || accept) begin
         hold_cnt <= '0;
         first_q  <= 1'b1;
      end else if (rpt) begin
         hold_cnt <= '0;
         first_q  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end
`else
   assign rpt = 1'b0;
`endif

   assign level = stable;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button debounce/pulse and switch synchronisation ahead of the calculator FSM.
// Define BTN_REPEAT_EN to add hold-to-repeat on btn_press.
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int CLK_FREQ    = 25_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int N_BTN       = 5,
   parameter int N_SW        = 16,
   parameter int HOLD_MS     = 500,
   parameter int REPEAT_MS   = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_SW-1:0]  sw_sync,
   output logic             sw_change
);

   localparam int DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
`ifdef BTN_REPEAT_EN
   localparam int HOLD_CYCLES   = ms_to_cycles(CLK_FREQ, HOLD_MS);
   localparam int REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
`endif

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(
         .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_REPEAT_EN
        ,.HOLD_CYCLES   (HOLD_CYCLES)
        ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i])
      );
   end

   logic [N_SW-1:0] sw_s1;
   logic [N_SW-1:0] sw_sync_d;

   // Switches are level controls, so synchronise only; no debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1     <= '0;
         sw_sync   <= '0;
         sw_sync_d <= '0;
         sw_change <= 1'b0;
      end else begin
         sw_s1     <= sw_raw;
         sw_sync   <= sw_s1;
         sw_sync_d <= sw_sync;
         sw_change <= (sw_sync != sw_sync_d);
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed + random bench for btn_conditioner against a behavioural model.
// Expected repeat counts follow BTN_REPEAT_EN.
module tb_btn_conditioner;

   localparam int CF   = 1000;
   localparam int DBMS = 4;
   localparam int HMS  = 10;
   localparam int RMS  = 5;
   localparam int NB   = 5;
   localparam int NS   = 16;
   localparam int DB   = CF / 1000 * DBMS;
   localparam int HOLD = CF / 1000 * HMS;
   localparam int REP  = CF / 1000 * RMS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic [NS-1:0] sw_raw = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release;
   logic [NS-1:0] sw_sync;
   logic          sw_change;

   btn_conditioner #(
      .CLK_FREQ    (CF),
      .DEBOUNCE_MS (DBMS),
      .N_BTN       (NB),
      .N_SW        (NS),
      .HOLD_MS     (HMS),
      .REPEAT_MS   (RMS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .sw_raw      (sw_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .sw_sync     (sw_sync),
      .sw_change   (sw_change)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [NB-1:0] m_level, m_press, m_rel;
   logic [NS-1:0] m_sync;
   logic          m_chg;
   int            run   [NB];
   int            held  [NB];
   bit            first [NB];
   logic [NB-1:0] bq [$];
   logic [NS-1:0] sq [$];

   int pcount [NB];
   int rcount [NB];
   int first_press [NB];
   int ccount;
   int first_chg;

   task automatic m_reset();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_sync  = '0;
      m_chg   = 1'b0;
      for (int i = 0; i < NB; i++) begin
         run[i]   = 0;
         held[i]  = 0;
         first[i] = 1'b1;
      end
      bq.delete();
      sq.delete();
      repeat (2) bq.push_back('0);
      repeat (3) sq.push_back('0);
   endtask

   // Button seen by the debouncer is the raw sample from two edges back;
   // a level is accepted after DB consecutive disagreeing cycles.
   task automatic m_edge();
      logic [NB-1:0] d;
      logic [NB-1:0] junk_b;
      logic [NS-1:0] junk_s;
      bit            acc;
      if (!rst_n) begin
         m_reset();
         return;
      end
      d = bq[bq.size()-2];
      bq.push_back(btn_raw);
      if (bq.size() > 4) junk_b = bq.pop_front();
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NB; i++) begin
         acc = 1'b0;
         if (d[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == DB) begin
               m_level[i] = d[i];
               m_press[i] = d[i];
               m_rel[i]   = ~d[i];
               run[i]     = 0;
               acc        = 1'b1;
            end
         end else begin
            run[i] = 0;
         end
`ifdef BTN_REPEAT_EN
         if (!m_level[i] || acc) begin
            held[i]  = 0;
            first[i] = 1'b1;
         end else begin
            held[i]++;
            if (held[i] == (first[i] ? HOLD : REP)) begin
               m_press[i] = 1'b1;
               held[i]    = 0;
               first[i]   = 1'b0;
            end
         end
`endif
      end
      m_chg = (sq[sq.size()-2] != sq[sq.size()-3]);
      sq.push_back(sw_raw);
      if (sq.size() > 5) junk_s = sq.pop_front();
      m_sync = sq[sq.size()-2];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
                tag, obs, exp, cyc);
      end
   endtask

   task automatic clr_counts();
      for (int i = 0; i < NB; i++) begin
         pcount[i]      = 0;
         rcount[i]      = 0;
         first_press[i] = -1;
      end
      ccount    = 0;
      first_chg = -1;
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      cyc++;
      #1;
      chk("level",   32'(btn_level),   32'(m_level));
      chk("press",   32'(btn_press),   32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      chk("sw_sync", 32'(sw_sync),     32'(m_sync));
      chk("sw_chg",  32'(sw_change),   32'(m_chg));
      for (int i = 0; i < NB; i++) begin
         if (btn_press[i]) begin
            pcount[i]++;
            if (first_press[i] < 0) first_press[i] = cyc;
         end
         if (btn_release[i]) rcount[i]++;
      end
      if (sw_change) begin
         ccount++;
         if (first_chg < 0) first_chg = cyc;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) step();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_level"}, 32'(btn_level),   0);
      chk({tag, "_press"}, 32'(btn_press),   0);
      chk({tag, "_rel"},   32'(btn_release), 0);
      chk({tag, "_sw"},    32'(sw_sync),     0);
      chk({tag, "_chg"},   32'(sw_change),   0);
   endtask

   int t0;
   int exp_rep;

   initial begin
      m_reset();
      clr_counts();
      btn_raw = '1;
      sw_raw  = '1;
      cycles(2);
      chk_zero("rst");
      btn_raw = '0;
      sw_raw  = '0;
      rst_n   = 1'b1;
      cycles(4);

      // clean press on button 0
      clr_counts();
      btn_raw[0] = 1'b1;
      t0 = cyc;
      cycles(10);
      chk("clean_lat", 32'(first_press[0] - t0), 6);
      chk("clean_cnt", 32'(pcount[0]), 1);
      chk("clean_rel", 32'(rcount[0]), 0);

      // bounce on button 1
      clr_counts();
      btn_raw[1] = 1'b1; step();
      btn_raw[1] = 1'b0; step();
      btn_raw[1] = 1'b1; step();
      btn_raw[1] = 1'b0; step();
      btn_raw[1] = 1'b1;
      t0 = cyc;
      cycles(10);
      chk("bounce_cnt", 32'(pcount[1]), 1);
      chk("bounce_lat", 32'(first_press[1] - t0), 6);

      // glitch then real release on button 0
      clr_counts();
      btn_raw[0] = 1'b0;
      cycles(3);
      btn_raw[0] = 1'b1;
      cycles(8);
      chk("glitch_rel", 32'(rcount[0]), 0);
      btn_raw[0] = 1'b0;
      cycles(10);
      chk("release_cnt", 32'(rcount[0]), 1);
      chk("release_lvl", 32'(btn_level[0]), 0);

      // simultaneous press of buttons 0 and 3
      clr_counts();
      btn_raw[0] = 1'b1;
      btn_raw[3] = 1'b1;
      t0 = cyc;
      cycles(8);
      chk("simul_lat0", 32'(first_press[0] - t0), 6);
      chk("simul_lat3", 32'(first_press[3] - t0), 6);

      // reset two cycles into PENDING
      btn_raw = '0;
      cycles(10);
      btn_raw[2] = 1'b1;
      cycles(4);
      rst_n = 1'b0;
      m_reset();
      #1;
      chk_zero("midrst");
      cycles(2);
      clr_counts();
      rst_n = 1'b1;
      t0 = cyc;
      cycles(8);
      chk("rst_lat", 32'(first_press[2] - t0), 6);
      chk("rst_cnt", 32'(pcount[2]), 1);

      // switch change
      clr_counts();
      sw_raw = 16'h8001;
      t0 = cyc;
      cycles(2);
      chk("sw_2edge", 32'(sw_sync), 32'h8001);
      cycles(4);
      chk("sw_chg_cnt", 32'(ccount), 1);
      chk("sw_chg_lat", 32'(first_chg - t0), 3);

      // hold behaviour on button 4
      btn_raw = '0;
      cycles(10);
      clr_counts();
      btn_raw[4] = 1'b1;
      cycles(30);
      btn_raw[4] = 1'b0;
      cycles(10);
`ifdef BTN_REPEAT_EN
      exp_rep = 5;
`else
      exp_rep = 1;
`endif
      chk("hold_cnt", 32'(pcount[4]), 32'(exp_rep));
      chk("hold_rel", 32'(rcount[4]), 1);

      // random button and switch activity
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
         if ($urandom_range(0, 19) == 0) sw_raw = NS'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
